// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, branch/jump redirect and one-entry stall buffer.
// Define FETCH_DELAY_SLOT_EN for MIPS delay-slot semantics; by default the post-redirect word is squashed.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] instr_id,
    output logic [5:0]  op_id,
    output logic [31:0] pcplus4_id,
    output logic        valid_id,
    output logic        redirect
);
    // state      | meaning
    // S_IDLE     | one idle cycle after reset, no request
    // S_FETCH    | request pc_f, consume word on ready
    // S_BUFFERED | word parked in buffer while ID is held
    // S_REDIRECT | finish in-flight access, then jump to saved target
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_BUFFERED, S_REDIRECT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc_f, w_pc_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic [31:0] r_saved, w_saved_nxt;
    logic [31:0] r_instr_id, w_instr_nxt;
    logic [31:0] r_pcplus4_id, w_pcplus4_nxt;
    logic        r_valid_id, w_valid_nxt;
    logic        w_req;

    logic        w_hold, w_take;
    logic [31:0] w_pc_inc, w_jump_tgt, w_br_tgt, w_target;

    assign w_hold     = stall & r_valid_id;
    assign w_take     = r_valid_id & ~stall & (jump | (branch & zero));
    assign w_pc_inc   = r_pc_f + 32'd4;
    assign w_jump_tgt = {r_pcplus4_id[31:28], r_instr_id[25:0], 2'b00};
    assign w_br_tgt   = r_pcplus4_id + {{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00};
    assign w_target   = jump ? w_jump_tgt : w_br_tgt;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc_f;
        w_buf_nxt     = r_buf;
        w_saved_nxt   = r_saved;
        w_instr_nxt   = r_instr_id;
        w_pcplus4_nxt = r_pcplus4_id;
        w_valid_nxt   = r_valid_id;
        w_req         = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ready) begin
                    if (w_take) begin
                        w_pc_nxt = w_target;
`ifdef FETCH_DELAY_SLOT_EN
                        w_instr_nxt   = imem_rdata;
                        w_pcplus4_nxt = w_pc_inc;
                        w_valid_nxt   = 1'b1;
`else
                        w_valid_nxt   = 1'b0;
`endif
                    end else if (w_hold) begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = S_BUFFERED;
                    end else begin
                        w_instr_nxt   = imem_rdata;
                        w_pcplus4_nxt = w_pc_inc;
                        w_valid_nxt   = 1'b1;
                        w_pc_nxt      = w_pc_inc;
                    end
                end else if (w_take) begin
                    // address must stay on the bus until the pending access completes
                    w_saved_nxt = w_target;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REDIRECT;
                end
            end
            S_BUFFERED: begin
                if (!w_hold) begin
                    w_state_nxt = S_FETCH;
                    if (w_take) begin
                        w_pc_nxt = w_target;
`ifdef FETCH_DELAY_SLOT_EN
                        w_instr_nxt   = r_buf;
                        w_pcplus4_nxt = w_pc_inc;
                        w_valid_nxt   = 1'b1;
`else
                        w_valid_nxt   = 1'b0;
`endif
                    end else begin
                        w_instr_nxt   = r_buf;
                        w_pcplus4_nxt = w_pc_inc;
                        w_valid_nxt   = 1'b1;
                        w_pc_nxt      = w_pc_inc;
                    end
                end
            end
            S_REDIRECT: begin
                w_req = 1'b1;
                if (imem_ready) begin
                    w_pc_nxt    = r_saved;
                    w_state_nxt = S_FETCH;
`ifdef FETCH_DELAY_SLOT_EN
                    w_instr_nxt   = imem_rdata;
                    w_pcplus4_nxt = w_pc_inc;
                    w_valid_nxt   = 1'b1;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_pc_f       <= RESET_PC;
            r_buf        <= 32'd0;
            r_saved      <= 32'd0;
            r_instr_id   <= 32'd0;
            r_pcplus4_id <= 32'd0;
            r_valid_id   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc_f       <= w_pc_nxt;
            r_buf        <= w_buf_nxt;
            r_saved      <= w_saved_nxt;
            r_instr_id   <= w_instr_nxt;
            r_pcplus4_id <= w_pcplus4_nxt;
            r_valid_id   <= w_valid_nxt;
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc_f;
    assign instr_id   = r_instr_id;
    assign op_id      = r_instr_id[31:26];
    assign pcplus4_id = r_pcplus4_id;
    assign valid_id   = r_valid_id;
    assign redirect   = w_take;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main core at RESET_PC 0, a jump core at 0x3000_0000,
// and a wrap core at 0xFFFF_FFF8, all sharing clock and reset.
module tb_fetch_stage;
    logic clk;
    logic reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        req_m, rdy_m, stall_m, br_m, zero_m, jmp_m, valid_m, redir_m;
    logic [31:0] addr_m, rdata_m, instr_m, pcp4_m;
    logic [5:0]  op_m;

    function automatic logic [31:0] mem_main(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h1000_0003;  // beq +3 -> 0x20
            32'h0000_0030: return 32'h1000_0004;  // beq +4 -> 0x44
            default:       return a;
        endcase
    endfunction

    assign rdata_m = mem_main(addr_m);
    assign br_m    = (op_m == 6'h04);
    assign jmp_m   = (op_m == 6'h02);
    assign zero_m  = 1'b1;

    fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset_n(reset_n), .imem_req(req_m), .imem_addr(addr_m),
        .imem_ready(rdy_m), .imem_rdata(rdata_m), .stall(stall_m), .branch(br_m),
        .zero(zero_m), .jump(jmp_m), .instr_id(instr_m), .op_id(op_m),
        .pcplus4_id(pcp4_m), .valid_id(valid_m), .redirect(redir_m)
    );

    // jump instance: j at 0x3000_0004 with branch also asserted
    logic        req_j, valid_j, redir_j, br_j;
    logic [31:0] addr_j, rdata_j, instr_j, pcp4_j;
    logic [5:0]  op_j;

    assign rdata_j = (addr_j == 32'h3000_0004) ? 32'h0800_0040 : addr_j;
    assign br_j    = (op_j == 6'h02);

    fetch_stage #(.RESET_PC(32'h3000_0000)) u_dut_j (
        .clk(clk), .reset_n(reset_n), .imem_req(req_j), .imem_addr(addr_j),
        .imem_ready(req_j), .imem_rdata(rdata_j), .stall(1'b0), .branch(br_j),
        .zero(1'b1), .jump(br_j), .instr_id(instr_j), .op_id(op_j),
        .pcplus4_id(pcp4_j), .valid_id(valid_j), .redirect(redir_j)
    );

    // wrap instance
    logic        req_h, valid_h, redir_h;
    logic [31:0] addr_h, instr_h, pcp4_h;
    logic [5:0]  op_h;

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_h (
        .clk(clk), .reset_n(reset_n), .imem_req(req_h), .imem_addr(addr_h),
        .imem_ready(req_h), .imem_rdata(addr_h), .stall(1'b0), .branch(1'b0),
        .zero(1'b0), .jump(1'b0), .instr_id(instr_h), .op_id(op_h),
        .pcplus4_id(pcp4_h), .valid_id(valid_h), .redirect(redir_h)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        rdy_m   = 1'b1;
        stall_m = 1'b0;
        step();
        step();
        check("rst_req",     32'(req_m), 32'd0);
        check("rst_addr",    addr_m, 32'h0);
        check("rst_instr",   instr_m, 32'h0);
        check("rst_pcp4",    pcp4_m, 32'h0);
        check("rst_valid",   32'(valid_m), 32'd0);
        check("rst_redir",   32'(redir_m), 32'd0);
        check("rst_addr_hi", addr_h, 32'hFFFF_FFF8);
        reset_n = 1'b1;

        step(); // cycle 1
        check("c1_addr",    addr_m, 32'h0);
        check("c1_req",     32'(req_m), 32'd1);
        check("c1_valid",   32'(valid_m), 32'd0);
        check("c1_addr_hi", addr_h, 32'hFFFF_FFF8);
        step(); // cycle 2
        check("c2_addr",    addr_m, 32'h4);
        check("c2_pcp4",    pcp4_m, 32'h4);
        check("c2_valid",   32'(valid_m), 32'd1);
        check("c2_addr_hi", addr_h, 32'hFFFF_FFFC);
        check("c2_pcp4_hi", pcp4_h, 32'hFFFF_FFFC);
        check("c2_addr_j",  addr_j, 32'h3000_0004);
        step(); // cycle 3
        check("c3_addr",     addr_m, 32'h8);
        check("c3_pcp4",     pcp4_m, 32'h8);
        check("c3_addr_hi",  addr_h, 32'h0000_0000);
        check("c3_pcp4_hi",  pcp4_h, 32'h0000_0000);
        check("c3_instr_hi", instr_h, 32'hFFFF_FFFC);
        check("c3_op_hi",    32'(op_h), 32'h3F);
        check("c3_redir_hi", 32'(redir_h), 32'd0);
        check("c3_valid_hi", 32'(valid_h), 32'd1);
        check("c3_req_hi",   32'(req_h), 32'd1);
        check("c3_instr_j",  instr_j, 32'h0800_0040);
        check("c3_op_j",     32'(op_j), 32'h02);
        check("c3_pcp4_j",   pcp4_j, 32'h3000_0008);
        check("c3_redir_j",  32'(redir_j), 32'd1);
        step(); // cycle 4
        check("c4_addr",    addr_m, 32'hC);
        check("c4_pcp4",    pcp4_m, 32'hC);
        check("c4_addr_j",  addr_j, 32'h3000_0100);
        check("c4_req_j",   32'(req_j), 32'd1);
`ifdef FETCH_DELAY_SLOT_EN
        check("c4_valid_j", 32'(valid_j), 32'd1);
        check("c4_instr_j", instr_j, 32'h3000_0008);
`else
        check("c4_valid_j", 32'(valid_j), 32'd0);
`endif
        step(); // cycle 5
        check("c5_addr", addr_m, 32'h10);
        step(); // cycle 6: beq in ID
        check("c6_instr", instr_m, 32'h1000_0003);
        check("c6_op",    32'(op_m), 32'h04);
        check("c6_redir", 32'(redir_m), 32'd1);
        check("c6_addr",  addr_m, 32'h14);
        step(); // cycle 7
        check("c7_addr",  addr_m, 32'h20);
        check("c7_redir", 32'(redir_m), 32'd0);
`ifdef FETCH_DELAY_SLOT_EN
        check("c7_valid", 32'(valid_m), 32'd1);
        check("c7_instr", instr_m, 32'h14);
        check("c7_pcp4",  pcp4_m, 32'h18);
`else
        check("c7_valid", 32'(valid_m), 32'd0);
`endif
        step(); // cycle 8
        check("c8_instr", instr_m, 32'h20);
        check("c8_valid", 32'(valid_m), 32'd1);
        check("c8_pcp4",  pcp4_m, 32'h24);
        check("c8_addr",  addr_m, 32'h24);
        rdy_m   = 1'b0;
        stall_m = 1'b1;
        step(); // cycle 9: pending access, stalled
        check("c9_addr",  addr_m, 32'h24);
        check("c9_req",   32'(req_m), 32'd1);
        check("c9_instr", instr_m, 32'h20);
        rdy_m = 1'b1;
        step(); // cycle 10: word buffered
        check("c10_req",   32'(req_m), 32'd0);
        check("c10_instr", instr_m, 32'h20);
        step(); // cycle 11
        check("c11_req",   32'(req_m), 32'd0);
        check("c11_instr", instr_m, 32'h20);
        stall_m = 1'b0;
        step(); // cycle 12: buffered word enters ID
        check("c12_instr", instr_m, 32'h24);
        check("c12_pcp4",  pcp4_m, 32'h28);
        check("c12_valid", 32'(valid_m), 32'd1);
        check("c12_req",   32'(req_m), 32'd1);
        check("c12_addr",  addr_m, 32'h28);
        step(); // cycle 13
        check("c13_instr", instr_m, 32'h28);
        step(); // cycle 14
        check("c14_instr", instr_m, 32'h2C);
        check("c14_addr",  addr_m, 32'h30);
        step(); // cycle 15: beq in ID, memory stalls 4 cycles
        check("c15_instr", instr_m, 32'h1000_0004);
        check("c15_redir", 32'(redir_m), 32'd1);
        check("c15_addr",  addr_m, 32'h34);
        rdy_m = 1'b0;
        step(); // cycle 16
        check("c16_addr",  addr_m, 32'h34);
        check("c16_valid", 32'(valid_m), 32'd0);
        check("c16_req",   32'(req_m), 32'd1);
        check("c16_redir", 32'(redir_m), 32'd0);
        step(); // cycle 17
        check("c17_addr", addr_m, 32'h34);
        step(); // cycle 18
        check("c18_addr", addr_m, 32'h34);
        check("c18_req",  32'(req_m), 32'd1);
        step(); // cycle 19
        check("c19_addr", addr_m, 32'h34);
        rdy_m = 1'b1;
        step(); // cycle 20
        check("c20_addr", addr_m, 32'h44);
`ifdef FETCH_DELAY_SLOT_EN
        check("c20_valid", 32'(valid_m), 32'd1);
        check("c20_instr", instr_m, 32'h34);
        check("c20_pcp4",  pcp4_m, 32'h38);
`else
        check("c20_valid", 32'(valid_m), 32'd0);
`endif
        step(); // cycle 21
        check("c21_instr", instr_m, 32'h44);
        check("c21_pcp4",  pcp4_m, 32'h48);
        check("c21_valid", 32'(valid_m), 32'd1);
        rdy_m = 1'b0;
        step(); // cycle 22: access pending, then async reset
        check("c22_req",   32'(req_m), 32'd1);
        check("c22_addr",  addr_m, 32'h48);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req",   32'(req_m), 32'd0);
        check("arst_valid", 32'(valid_m), 32'd0);
        check("arst_addr",  addr_m, 32'h0);
        check("arst_instr", instr_m, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
